mux_scan_ctrl: RTL and testbench

Round-robin scan controller that sits directly upstream of the 4:1 channel mux: it drives the mux select lines S1/S0 and captures the mux output back into a 4-bit frame. It steps through the enabled channels and holds each select for a programmable settle time. It samples the mux output once per channel and presents the assembled frame on a valid/ready handshake. Single-shot or continuous scanning.

---
 rtl/mux_scan_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// Round-robin scan controller for a 4:1 channel mux: drives the selects, holds each
// for SETTLE cycles, samples the mux output per enabled channel and hands out a 4-bit frame.
module mux_scan_ctrl #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cont,
    input  logic [3:0] ch_en,
    input  logic       mux_out,
    output logic       S1,
    output logic       S0,
    output logic [3:0] frame,
    output logic       frame_valid,
    input  logic       frame_ready,
    output logic       busy,
    output logic [7:0] frame_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_VALID  = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    function automatic logic [1:0] lowest_idx(input logic [3:0] mask);
        logic [1:0] res;
        res = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) begin
                res = 2'(i);
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [3:0] above_mask(input logic [1:0] idx);
        return 4'b1110 << idx;
    endfunction

    state_t     r_state;
    logic [1:0] r_idx;
    logic [3:0] r_cnt;
    logic [3:0] r_acc;
    logic [3:0] r_en_q;
    logic [3:0] r_frame;
    logic       r_frame_valid;
    logic [7:0] r_frame_cnt;
    logic       r_busy;

    state_t     w_state_nxt;
    logic [1:0] w_idx_nxt;
    logic [3:0] w_cnt_nxt;
    logic [3:0] w_acc_nxt;
    logic [3:0] w_en_nxt;
    logic [3:0] w_frame_nxt;
    logic       w_fv_nxt;
    logic [7:0] w_fcnt_nxt;
    logic       w_busy_nxt;
    logic [3:0] w_acc_smp;
    logic [3:0] w_above;

    // acc bit for the current channel is always clear before its sample, so OR merges it in
    assign w_acc_smp = r_acc | ({3'b000, mux_out} << r_idx);
    assign w_above   = r_en_q & above_mask(r_idx);

    // Next-state and next-output decode of the scan FSM
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_acc_nxt   = r_acc;
        w_en_nxt    = r_en_q;
        w_frame_nxt = r_frame;
        w_fv_nxt    = r_frame_valid;
        w_fcnt_nxt  = r_frame_cnt;
        case (r_state)
            ST_IDLE: begin
                w_idx_nxt = 2'd0;
                if (start && (ch_en != 4'd0)) begin
                    w_en_nxt    = ch_en;
                    w_acc_nxt   = 4'd0;
                    w_idx_nxt   = lowest_idx(ch_en);
                    w_cnt_nxt   = CNT_INIT;
                    w_state_nxt = ST_SETTLE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_acc_nxt = w_acc_smp;
                    if (w_above != 4'd0) begin
                        w_idx_nxt = lowest_idx(w_above);
                        w_cnt_nxt = CNT_INIT;
                    end else begin
                        w_frame_nxt = w_acc_smp;
                        w_fv_nxt    = 1'b1;
                        w_state_nxt = ST_VALID;
                    end
                end
            end
            ST_VALID: begin
                if (r_frame_valid && frame_ready) begin
                    w_fv_nxt   = 1'b0;
                    w_fcnt_nxt = r_frame_cnt + 8'd1;
                    if (cont && (ch_en != 4'd0)) begin
                        w_en_nxt    = ch_en;
                        w_acc_nxt   = 4'd0;
                        w_idx_nxt   = lowest_idx(ch_en);
                        w_cnt_nxt   = CNT_INIT;
                        w_state_nxt = ST_SETTLE;
                    end else begin
                        w_idx_nxt   = 2'd0;
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_fv_nxt = r_frame_valid;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = 2'd0;
                w_fv_nxt    = 1'b0;
            end
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_idx         <= 2'd0;
            r_cnt         <= 4'd0;
            r_acc         <= 4'd0;
            r_en_q        <= 4'd0;
            r_frame       <= 4'd0;
            r_frame_valid <= 1'b0;
            r_frame_cnt   <= 8'd0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_cnt         <= w_cnt_nxt;
            r_acc         <= w_acc_nxt;
            r_en_q        <= w_en_nxt;
            r_frame       <= w_frame_nxt;
            r_frame_valid <= w_fv_nxt;
            r_frame_cnt   <= w_fcnt_nxt;
            r_busy        <= w_busy_nxt;
        end
    end

    assign S1          = r_idx[1];
    assign S0          = r_idx[0];
    assign frame       = r_frame;
    assign frame_valid = r_frame_valid;
    assign busy        = r_busy;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: a SETTLE=2 instance under directed/random scans and
// a SETTLE=1 instance in continuous single-channel mode to exercise frame_cnt wrap.
module tb_mux_scan_ctrl;

    localparam int P_SET = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, cont, mux_out, S1, S0, frame_valid, frame_ready, busy;
    logic [3:0] ch_en, frame, mux_in;
    logic [7:0] frame_cnt;

    logic       start2, cont2, mux_out2, S1_2, S0_2, fv2, rdy2, busy2;
    logic [3:0] ch_en2, frame2, mux_in2;
    logic [7:0] fcnt2;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [3:0] frame;
        int         vcyc;
    } exp_t;
    exp_t       sb[$];
    logic [1:0] exp_sel[int];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mux_out  = mux_in[{S1, S0}];
    assign mux_out2 = mux_in2[{S1_2, S0_2}];

    mux_scan_ctrl #(.SETTLE(P_SET)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .ch_en(ch_en),
        .mux_out(mux_out), .S1(S1), .S0(S0), .frame(frame), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .busy(busy), .frame_cnt(frame_cnt)
    );

    mux_scan_ctrl #(.SETTLE(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .cont(cont2), .ch_en(ch_en2),
        .mux_out(mux_out2), .S1(S1_2), .S0(S0_2), .frame(frame2), .frame_valid(fv2),
        .frame_ready(rdy2), .busy(busy2), .frame_cnt(fcnt2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference model: channel k of the scan owns cycles E0+k*SETTLE .. E0+(k+1)*SETTLE-1,
    // and the frame (inputs masked by the enable set) becomes valid at E0+N*SETTLE.
    task automatic start_scan(input logic [3:0] en);
        int e0;
        int n;
        start = 1'b1;
        ch_en = en;
        e0    = cyc + 1;
        n     = 0;
        if (en != 4'd0) begin
            for (int k = 0; k < 4; k++) begin
                if (en[k]) begin
                    for (int j = 0; j < P_SET; j++) exp_sel[e0 + n * P_SET + j] = 2'(k);
                    n++;
                end
            end
            sb.push_back('{mux_in & en, e0 + n * P_SET});
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk);
            #1;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_valid(input int bound);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk);
            #1;
            if (frame_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("valid_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_sel"}, {30'd0, S1, S0}, 32'd0);
        check({tag, "_frame"}, {28'd0, frame}, 32'd0);
        check({tag, "_valid"}, {31'd0, frame_valid}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_cnt"}, {24'd0, frame_cnt}, 32'd0);
    endtask

    // Monitor for the SETTLE=2 instance: selects, valid timing, frames, accepted-frame count
    initial begin : mon1
        logic [7:0] exp_cnt;
        logic       prev_v;
        exp_t       e;
        exp_cnt = 8'd0;
        prev_v  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_cnt = 8'd0;
                prev_v  = 1'b0;
            end else begin
                check("frame_cnt", {24'd0, frame_cnt}, {24'd0, exp_cnt});
                if (exp_sel.exists(cyc)) check("select", {30'd0, S1, S0}, {30'd0, exp_sel[cyc]});
                if (!busy) check("idle_sel", {30'd0, S1, S0}, 32'd0);
                if (frame_valid && !prev_v) begin
                    if (sb.size() == 0) fail_now("unexpected_valid");
                    else check("valid_cycle", cyc, sb[0].vcyc);
                end
                if (frame_valid && frame_ready) begin
                    if (sb.size() == 0) begin
                        fail_now("unexpected_handshake");
                    end else begin
                        e = sb.pop_front();
                        check("frame", {28'd0, frame}, {28'd0, e.frame});
                    end
                    exp_cnt = exp_cnt + 8'd1;
                end
                prev_v = frame_valid;
            end
        end
    end

    int hs2 = 0;

    // Monitor for the continuous SETTLE=1 instance: one frame of I0 every 2 cycles
    initial begin : mon2
        logic [7:0] exp_cnt2;
        int         last_hs;
        exp_cnt2 = 8'd0;
        last_hs  = -1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_cnt2 = 8'd0;
                last_hs  = -1;
            end else begin
                check("cnt2", {24'd0, fcnt2}, {24'd0, exp_cnt2});
                if (busy2) check("sel2", {30'd0, S1_2, S0_2}, 32'd0);
                if (fv2 && rdy2) begin
                    check("frame2", {28'd0, frame2}, {31'd0, mux_in2[0]});
                    if (last_hs >= 0) check("period2", cyc - last_hs, 32'd2);
                    last_hs  = cyc;
                    exp_cnt2 = exp_cnt2 + 8'd1;
                    hs2++;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [3:0] en;
        rst_n = 1'b0; start = 1'b0; cont = 1'b0; ch_en = 4'd0; frame_ready = 1'b1; mux_in = 4'd0;
        start2 = 1'b0; cont2 = 1'b0; ch_en2 = 4'd0; rdy2 = 1'b1; mux_in2 = 4'd0;
        @(negedge clk);
        check_reset_outs("rst0");
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Full scan
        mux_in = 4'b1010;
        start_scan(4'b1111);
        wait_idle(40);
        check("full_frame_held", {28'd0, frame}, 32'h0000000a);

        // Sparse mask
        mux_in = 4'b1111;
        start_scan(4'b0101);
        wait_idle(40);
        check("sparse_frame_held", {28'd0, frame}, 32'h00000005);

        // start with nothing enabled is ignored
        start_scan(4'b0000);
        check("zero_mask_busy", {31'd0, busy}, 32'd0);

        // Back-pressure with mux inputs moving while frame is held
        frame_ready = 1'b0;
        mux_in = 4'b0110;
        start_scan(4'b1011);
        wait_valid(40);
        repeat (5) begin
            @(posedge clk); #1;
            mux_in = 4'($urandom);
            check("bp_valid", {31'd0, frame_valid}, 32'd1);
            check("bp_frame", {28'd0, frame}, 32'h00000002);
        end
        frame_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_valid_drop", {31'd0, frame_valid}, 32'd0);
        wait_idle(10);

        // Random scans, mid-scan start/ch_en noise, random back-pressure
        for (int t = 0; t < 14; t++) begin
            en = 4'($urandom);
            mux_in = 4'($urandom);
            frame_ready = 1'b0;
            start_scan(en);
            if (en == 4'd0) begin
                check("rand_zero_busy", {31'd0, busy}, 32'd0);
                continue;
            end
            repeat ($urandom_range(0, 3)) begin
                start = 1'b1;
                ch_en = 4'($urandom);
                @(posedge clk); #1;
            end
            start = 1'b0;
            begin : rwait
                bit ok;
                ok = 1'b0;
                for (int i = 0; i < 200; i++) begin
                    @(posedge clk); #1;
                    frame_ready = 1'($urandom);
                    if (frame_valid) mux_in = 4'($urandom);
                    if (!busy) begin
                        ok = 1'b1;
                        break;
                    end
                end
                check("rand_idle_timeout", {31'd0, ok}, 32'd1);
            end
        end

        // Async reset during SETTLE
        frame_ready = 1'b1;
        mux_in = 4'b1001;
        start_scan(4'b1111);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_outs("rst_settle");
        sb.delete();
        exp_sel.delete();
        @(negedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        mux_in = 4'b0011;
        start_scan(4'b1111);
        wait_idle(40);
        check("post_rst_frame", {28'd0, frame}, 32'h00000003);

        // Async reset during VALID
        frame_ready = 1'b0;
        mux_in = 4'b1110;
        start_scan(4'b0110);
        wait_valid(40);
        #3 rst_n = 1'b0;
        #1 check_reset_outs("rst_valid");
        sb.delete();
        exp_sel.delete();
        @(negedge clk); #1 rst_n = 1'b1;
        frame_ready = 1'b1;
        @(posedge clk); #1;
        mux_in = 4'b0100;
        start_scan(4'b1100);
        wait_idle(40);
        check("post_rst2_frame", {28'd0, frame}, 32'h00000004);

        // Continuous single-channel run on the SETTLE=1 instance
        mux_in2 = 4'($urandom);
        ch_en2 = 4'b0001;
        cont2 = 1'b1;
        start2 = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 600; i++) begin
            start2 = 1'($urandom);
            @(posedge clk); #1;
        end
        start2 = 1'b0;
        cont2 = 1'b0;
        begin : w2
            bit ok;
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk); #1;
                if (!busy2) begin
                    ok = 1'b1;
                    break;
                end
            end
            check("cont_idle", {31'd0, ok}, 32'd1);
        end
        check("wrap_reached", {31'd0, (hs2 > 256)}, 32'd1);
        check("wrap_cnt", {24'd0, fcnt2}, {24'd0, 8'(hs2)});

        @(posedge clk); #1;
        check("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
